// File: rtl/guess_input_stage.sv
// guess_input_stage: input conditioning in front of the 1A2B game core.
// Synchronises the raw keys and guess switches, debounces the keys into
// single-cycle press pulses, screens guesses for repeated digits, holds an
// accepted guess on a valid/ready handshake and captures a non-zero seed
// from a free-running counter on every new-game press.
//
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   btn0, btn2, sw9       raw submit / new-game / show keys
//   hex0..hex2            raw 3-bit guess digit switches
//   guess_ready           core takes the guess this cycle
//   guess_valid           guess0..2 hold an accepted distinct guess
//   guess0..guess2        latched guess digits
//   dup_err               one-cycle pulse, submit rejected (repeated digit)
//   newgame_pulse         one-cycle pulse per debounced new-game press
//   show_pulse            one-cycle pulse per debounced show press
//   seed                  seed captured at the last new-game press

// Per-key debouncer: level follows lvl_i only after DEBOUNCE_CYCLES
// consecutive mismatching cycles; emits one registered pulse per press.
module guess_input_stage_deb #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,   // synchronous, active low
  input  logic lvl_i,   // synchronised level, pressed = 1
  output logic press_o
);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d, db_prev_q, press_q;

  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (lvl_i != db_q) begin
      if (cnt_q == CNT_LAST) db_d  = lvl_i;
      else                   cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q     <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      db_prev_q <= db_q;
      press_q   <= db_q & ~db_prev_q;   // rising edge only; release is silent
    end
  end

  assign press_o = press_q;
endmodule

module guess_input_stage #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn0,
  input  logic       btn2,
  input  logic       sw9,
  input  logic [2:0] hex0,
  input  logic [2:0] hex1,
  input  logic [2:0] hex2,
  input  logic       guess_ready,
  output logic       guess_valid,
  output logic [2:0] guess0,
  output logic [2:0] guess1,
  output logic [2:0] guess2,
  output logic       dup_err,
  output logic       newgame_pulse,
  output logic       show_pulse,
  output logic [8:0] seed
);
  localparam int NUM_KEYS = 3;
  localparam int RAW_W    = NUM_KEYS + 9;
  // Keys reset to their released pin level so reset never fakes a press.
  localparam logic [RAW_W-1:0] RAW_REL = {9'd0, {NUM_KEYS{KEY_ACTIVE_LOW}}};

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_e;

  logic [RAW_W-1:0]                  raw, sync_s;
  logic [SYNC_STAGES-1:0][RAW_W-1:0] sync_q;
  logic [NUM_KEYS-1:0]               key_lvl, press;
  logic [2:0][2:0]                   hex_s, guess_q, guess_d;
  state_e                            state_q, state_d;
  logic                              dup_q, dup_d;
  logic [8:0]                        free_q, seed_q, seed_d;
  logic                              distinct;

  // Bit order: {hex2, hex1, hex0, sw9, btn2, btn0}
  assign raw = {hex2, hex1, hex0, sw9, btn2, btn0};

  always_ff @(posedge clk) begin
    if (!rst) sync_q <= {SYNC_STAGES{RAW_REL}};
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  assign sync_s  = sync_q[SYNC_STAGES-1];
  assign key_lvl = sync_s[NUM_KEYS-1:0] ^ {NUM_KEYS{KEY_ACTIVE_LOW}};
  assign hex_s   = sync_s[RAW_W-1:NUM_KEYS];

  // press[0]=submit, press[1]=new game, press[2]=show
  guess_input_stage_deb #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb [NUM_KEYS-1:0] (
    .clk_i  (clk),
    .rst_i  (rst),
    .lvl_i  (key_lvl),
    .press_o(press)
  );

  assign distinct = (hex_s[0] != hex_s[1]) && (hex_s[0] != hex_s[2]) &&
                    (hex_s[1] != hex_s[2]);

  always_comb begin
    state_d = state_q;
    guess_d = guess_q;
    dup_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press[0]) begin
          if (distinct) begin
            guess_d = hex_s;
            state_d = S_HOLD;
          end else begin
            dup_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        // Submits here are dropped on purpose: one guess in flight at a time.
        if (guess_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Zero would stall an LFSR-style consumer, so it is swapped for a constant.
  always_comb begin
    seed_d = seed_q;
    if (press[1]) seed_d = (free_q == 9'd0) ? 9'h1A5 : free_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      guess_q <= '0;
      dup_q   <= 1'b0;
      free_q  <= '0;
      seed_q  <= '0;
    end else begin
      state_q <= state_d;
      guess_q <= guess_d;
      dup_q   <= dup_d;
      free_q  <= free_q + 9'd1;
      seed_q  <= seed_d;
    end
  end

  assign guess_valid   = (state_q == S_HOLD);
  assign guess0        = guess_q[0];
  assign guess1        = guess_q[1];
  assign guess2        = guess_q[2];
  assign dup_err       = dup_q;
  assign newgame_pulse = press[1];
  assign show_pulse    = press[2];
  assign seed          = seed_q;
endmodule

// File: tb/tb_guess_input_stage.sv
// Bench for guess_input_stage with DEBOUNCE_CYCLES=4, SYNC_STAGES=2,
// active-low keys. A cycle model (raw history queue, sliding stability
// window per key, pending-guess flag) predicts every output each cycle;
// directed scenarios add hand-computed literal expectations.
module tb_guess_input_stage;
  localparam int DEB = 4;
  localparam int SYN = 2;
  localparam logic [11:0] REL = 12'b000_000_000_111;

  logic       clk = 1'b0;
  logic       rst, btn0, btn2, sw9, guess_ready;
  logic [2:0] hex0, hex1, hex2;
  logic       guess_valid, dup_err, newgame_pulse, show_pulse;
  logic [2:0] guess0, guess1, guess2;
  logic [8:0] seed;

  guess_input_stage #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYN),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .clk(clk), .rst(rst), .btn0(btn0), .btn2(btn2), .sw9(sw9),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .guess_ready(guess_ready),
    .guess_valid(guess_valid), .guess0(guess0), .guess1(guess1),
    .guess2(guess2), .dup_err(dup_err), .newgame_pulse(newgame_pulse),
    .show_pulse(show_pulse), .seed(seed)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model state
  logic [11:0]    m_rh[$];
  bit [DEB-1:0]   m_win[3];
  bit             m_db[3], m_dbp[3], m_pulse[3];
  bit             m_hold = 0, m_dup = 0;
  logic [2:0]     m_g[3] = '{3'd0, 3'd0, 3'd0};
  logic [8:0]     m_cnt = 0, m_seed = 0;
  int             cyc = 0;

  // monitors
  int  gv_rise = 0, dup_cnt = 0, ng_cnt = 0, sh_cnt = 0;
  bit  gv_prev = 0;

  task automatic model_step();
    logic [11:0] s, rawv;
    bit sub, ng, lvl;
    rawv = {hex2, hex1, hex0, sw9, btn2, btn0};
    if (!rst) begin
      m_rh.delete();
      for (int i = 0; i < SYN; i++) m_rh.push_back(REL);
      for (int k = 0; k < 3; k++) begin
        m_win[k] = '0; m_db[k] = 0; m_dbp[k] = 0; m_pulse[k] = 0; m_g[k] = 3'd0;
      end
      m_hold = 0; m_dup = 0; m_cnt = 0; m_seed = 0; cyc = 0;
    end else begin
      s   = m_rh[SYN-1];             // what the synchronisers present now
      sub = m_pulse[0];
      ng  = m_pulse[1];
      m_dup = 0;
      if (m_hold) begin
        if (guess_ready) m_hold = 0;
      end else if (sub) begin
        if (s[5:3] != s[8:6] && s[5:3] != s[11:9] && s[8:6] != s[11:9]) begin
          m_g[0] = s[5:3]; m_g[1] = s[8:6]; m_g[2] = s[11:9]; m_hold = 1;
        end else m_dup = 1;
      end
      if (ng) m_seed = (m_cnt == 9'd0) ? 9'h1A5 : m_cnt;
      m_cnt = m_cnt + 9'd1;
      cyc++;
      for (int k = 0; k < 3; k++) begin
        m_pulse[k] = m_db[k] && !m_dbp[k];
        m_dbp[k]   = m_db[k];
        lvl        = !s[k];
        m_win[k]   = {m_win[k][DEB-2:0], lvl};
        // level flips once DEB consecutive samples all disagree with it
        if (m_win[k] == {DEB{!m_db[k]}}) m_db[k] = !m_db[k];
      end
      m_rh.push_front(rawv);
      void'(m_rh.pop_back());
    end
  endtask

  task automatic compare();
    checks++;
    if (guess_valid !== m_hold || guess0 !== m_g[0] || guess1 !== m_g[1] ||
        guess2 !== m_g[2] || dup_err !== m_dup || newgame_pulse !== m_pulse[1] ||
        show_pulse !== m_pulse[2] || seed !== m_seed) begin
      errors++;
      $display("FAIL model cyc=%0d got gv=%0d g=%0d/%0d/%0d dup=%0d ng=%0d sh=%0d seed=%0d required gv=%0d g=%0d/%0d/%0d dup=%0d ng=%0d sh=%0d seed=%0d",
               cyc, guess_valid, guess0, guess1, guess2, dup_err, newgame_pulse,
               show_pulse, seed, m_hold, m_g[0], m_g[1], m_g[2], m_dup,
               m_pulse[1], m_pulse[2], m_seed);
    end
    if (guess_valid === 1'b1 && !gv_prev) gv_rise++;
    gv_prev = (guess_valid === 1'b1);
    if (dup_err === 1'b1) dup_cnt++;
    if (newgame_pulse === 1'b1) ng_cnt++;
    if (show_pulse === 1'b1) sh_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc < target && n < 2000) begin tick(); n++; end
    chk("wait_cyc_reached", cyc, target);
  endtask

  // which: 0 guess_valid, 1 newgame_pulse, 2 show_pulse
  task automatic await(input int which, input int bound, input string name, output int at);
    bit hit;
    at = -1;
    for (int n = 0; n < bound; n++) begin
      tick();
      hit = (which == 0) ? (guess_valid === 1'b1) :
            (which == 1) ? (newgame_pulse === 1'b1) : (show_pulse === 1'b1);
      if (hit) begin at = cyc; break; end
    end
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL %s: timeout after %0d cycles, required event", name, bound);
    end
  endtask

  task automatic set_hex(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    hex0 = a; hex1 = b; hex2 = c;
    repeat (3) tick();
  endtask

  task automatic press_btn0();
    btn0 = 1'b0; repeat (10) tick();
    btn0 = 1'b1; repeat (10) tick();
  endtask

  task automatic accept(input string name);
    guess_ready = 1'b1; tick();
    guess_ready = 1'b0;
    chk(name, guess_valid, 0);
  endtask

  task automatic chk_guess(input string name, input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    chk({name, "_g0"}, guess0, a);
    chk({name, "_g1"}, guess1, b);
    chk({name, "_g2"}, guess2, c);
  endtask

  initial begin
    int at, c0, d0;
    rst = 1'b0; btn0 = 1'b1; btn2 = 1'b1; sw9 = 1'b1; guess_ready = 1'b0;
    hex0 = 3'd0; hex1 = 3'd0; hex2 = 3'd0;
    repeat (3) tick();
    chk("reset_gv", guess_valid, 0);
    chk("reset_seed", seed, 0);
    chk("reset_pulses", {dup_err, newgame_pulse, show_pulse}, 0);
    rst = 1'b1;

    // seed capture: counter reads 300 on the pulse cycle, show pressed alongside
    wait_cyc(293);
    btn2 = 1'b0; sw9 = 1'b0;
    await(1, 15, "newgame_300", at);
    chk("newgame_cycle", at, 300);
    chk("show_same_cycle", show_pulse, 1);
    tick();
    chk("seed_300", seed, 300);
    repeat (5) tick();
    btn2 = 1'b1; sw9 = 1'b1;
    // counter wraps to 0 on cycle 512
    wait_cyc(505);
    btn2 = 1'b0;
    await(1, 15, "newgame_wrap", at);
    chk("newgame_cycle_wrap", at, 512);
    tick();
    chk("seed_zero_subst", seed, 9'h1A5);
    repeat (5) tick();
    btn2 = 1'b1; repeat (10) tick();
    chk("newgame_count", ng_cnt, 2);
    chk("show_count", sh_cnt, 1);
    chk("seed_held", seed, 9'h1A5);

    // bounce rejection, then a real press
    set_hex(3'd1, 3'd2, 3'd3);
    for (int i = 0; i < 5; i++) begin
      btn0 = 1'b0; repeat (3) tick();
      btn0 = 1'b1; repeat (3) tick();
    end
    repeat (6) tick();
    chk("bounce_no_gv", gv_rise, 0);
    btn0 = 1'b0; c0 = cyc;
    await(0, 20, "bounce_hold_gv", at);
    chk("gv_latency_7_to_9", (at - c0 >= 7) && (at - c0 <= 9), 1);
    repeat (5) tick();
    btn0 = 1'b1; repeat (10) tick();
    chk("one_gv_after_hold", gv_rise, 1);
    chk_guess("bounce", 3'd1, 3'd2, 3'd3);
    accept("bounce_accept");

    // distinct guess handshake
    set_hex(3'd1, 3'd4, 3'd6);
    press_btn0();
    chk("hs_gv_up", guess_valid, 1);
    repeat (20) tick();
    chk("hs_gv_still_up", guess_valid, 1);
    chk_guess("hs", 3'd1, 3'd4, 3'd6);
    chk("hs_gv_rises", gv_rise, 2);
    accept("hs_accept");

    // duplicate digits
    set_hex(3'd3, 3'd3, 3'd5);
    d0 = dup_cnt;
    press_btn0();
    chk("dup_one_cycle", dup_cnt - d0, 1);
    chk("dup_no_gv", gv_rise, 2);
    chk_guess("dup_keep", 3'd1, 3'd4, 3'd6);

    // press while holding a guess
    set_hex(3'd2, 3'd0, 3'd7);
    press_btn0();
    chk("hold_gv_up", guess_valid, 1);
    set_hex(3'd5, 3'd6, 3'd7);
    press_btn0();
    chk("hold_still_up", guess_valid, 1);
    chk_guess("hold_keep", 3'd2, 3'd0, 3'd7);
    chk("hold_no_dup", dup_cnt - d0, 1);
    accept("hold_accept");
    repeat (20) tick();
    chk("hold_no_second_gv", gv_rise, 3);
    chk_guess("hold_after", 3'd2, 3'd0, 3'd7);

    // reset in HOLD with the submit key still held
    set_hex(3'd4, 3'd5, 3'd6);
    btn0 = 1'b0;
    await(0, 20, "pre_reset_gv", at);
    rst = 1'b0; tick();
    chk("rst_drops_gv", guess_valid, 0);
    rst = 1'b1;
    await(0, 20, "gv_after_reset", at);
    chk("gv_after_reset_latency", at, 8);
    chk_guess("after_rst", 3'd4, 3'd5, 3'd6);
    chk("gv_rises_total", gv_rise, 5);
    btn0 = 1'b1; repeat (10) tick();
    accept("final_accept");
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
